// File: rtl/lane_judge.sv
// lane_judge: controls one falling-coin lane, opens the hit window and scores the player's presses.
// Optional build macro LANE_JUDGE_EARLY_PENALTY_EN: a press while the coin is still travelling is a miss.
module lane_judge #(
  parameter int WINDOW_FRAMES   = 17,
  parameter int TRAVEL_TIMEOUT  = 64,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int SCORE_PER_HIT   = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_v_sync,
  input  logic        i_spawn_req,
  input  logic        i_button,
  input  logic        i_in_position,
  output logic        o_active,
  output logic        o_hit,
  output logic        o_miss,
  output logic        o_spawn_dropped,
  output logic [15:0] o_score,
  output logic [7:0]  o_combo,
  output logic [7:0]  o_best_combo,
  output logic [1:0]  o_state
);

  // state    | meaning
  // IDLE     | coin inactive, waiting for a spawn request or a pending spawn
  // TRAVEL   | coin falling, waiting for in_position or the travel timeout
  // WINDOW   | coin hittable, waiting for a press, zone exit or window expiry
  // COOLDOWN | coin held inactive so it can reset its position before the next spawn
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAVEL   = 2'd1,
    WINDOW   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [7:0]  WINDOW_LAST   = 8'(WINDOW_FRAMES - 1);
  localparam logic [7:0]  TRAVEL_LAST   = 8'(TRAVEL_TIMEOUT - 1);
  localparam logic [7:0]  COOLDOWN_LAST = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [16:0] SCORE_INC     = 17'(SCORE_PER_HIT);

  state_t      state, state_nxt;
  logic [7:0]  frame_cnt, frame_cnt_nxt;
  logic        pending, pending_nxt;
  logic        vs_meta, vs_sync, vs_prev;
  logic        btn_meta, btn_sync, btn_prev;
  logic        frame_tick, press, early_press;
  logic        do_hit, do_miss, do_drop;
  logic        active_nxt;
  logic [16:0] score_sum;
  logic [15:0] score_nxt;
  logic [7:0]  combo_nxt, best_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_meta  <= 1'b0;
      vs_sync  <= 1'b0;
      vs_prev  <= 1'b0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      vs_meta  <= i_v_sync;
      vs_sync  <= vs_meta;
      vs_prev  <= vs_sync;
      btn_meta <= i_button;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  assign frame_tick = vs_sync & ~vs_prev;
  assign press      = btn_sync & ~btn_prev;

`ifdef LANE_JUDGE_EARLY_PENALTY_EN
  assign early_press = press;
`else
  assign early_press = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      frame_cnt <= 8'd0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
      pending   <= pending_nxt;
    end
  end

  // in_position takes priority over an early press or timeout in TRAVEL
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    pending_nxt   = pending;
    do_hit        = 1'b0;
    do_miss       = 1'b0;
    do_drop       = 1'b0;
    if (i_spawn_req && (state != IDLE)) begin
      if (pending) do_drop = 1'b1;
      else         pending_nxt = 1'b1;
    end
    case (state)
      IDLE: begin
        if (i_spawn_req || pending) begin
          state_nxt     = TRAVEL;
          frame_cnt_nxt = 8'd0;
          pending_nxt   = 1'b0;
        end
      end
      TRAVEL: begin
        if (i_in_position) begin
          state_nxt     = WINDOW;
          frame_cnt_nxt = 8'd0;
        end else if (early_press) begin
          do_miss = 1'b1;
        end else if (frame_tick) begin
          if (frame_cnt == TRAVEL_LAST) do_miss = 1'b1;
          else                          frame_cnt_nxt = frame_cnt + 8'd1;
        end
      end
      WINDOW: begin
        if (press) begin
          do_hit = 1'b1;
        end else if (!i_in_position) begin
          do_miss = 1'b1;
        end else if (frame_tick) begin
          if (frame_cnt == WINDOW_LAST) do_miss = 1'b1;
          else                          frame_cnt_nxt = frame_cnt + 8'd1;
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          if (frame_cnt == COOLDOWN_LAST) begin
            state_nxt     = IDLE;
            frame_cnt_nxt = 8'd0;
          end else begin
            frame_cnt_nxt = frame_cnt + 8'd1;
          end
        end
      end
    endcase
    if (do_hit || do_miss) begin
      state_nxt     = COOLDOWN;
      frame_cnt_nxt = 8'd0;
    end
  end

  // active follows the state one cycle late, so it rises after TRAVEL entry and falls after COOLDOWN entry
  always_comb begin
    active_nxt = (state == TRAVEL) || (state == WINDOW);
    score_sum  = {1'b0, o_score} + SCORE_INC;
    score_nxt  = o_score;
    combo_nxt  = o_combo;
    best_nxt   = o_best_combo;
    if (do_hit) begin
      score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      combo_nxt = (o_combo == 8'hFF) ? 8'hFF : o_combo + 8'd1;
      if (combo_nxt > o_best_combo) best_nxt = combo_nxt;
    end else if (do_miss) begin
      combo_nxt = 8'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_active        <= 1'b0;
      o_hit           <= 1'b0;
      o_miss          <= 1'b0;
      o_spawn_dropped <= 1'b0;
      o_score         <= 16'd0;
      o_combo         <= 8'd0;
      o_best_combo    <= 8'd0;
    end else begin
      o_active        <= active_nxt;
      o_hit           <= do_hit;
      o_miss          <= do_miss;
      o_spawn_dropped <= do_drop;
      o_score         <= score_nxt;
      o_combo         <= combo_nxt;
      o_best_combo    <= best_nxt;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_lane_judge.sv
// Bench for lane_judge: directed scenarios with literal expectations plus random traffic,
// all cycles compared against a rule-level lane model.
module tb_lane_judge;
  logic        clk = 1'b0;
  logic        rst, v_sync, spawn, button, in_pos;
  logic        active, hit, miss, dropped;
  logic [15:0] score;
  logic [7:0]  combo, best;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;
  int hit_cnt = 0;
  int miss_cnt = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  lane_judge dut (
    .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_spawn_req(spawn),
    .i_button(button), .i_in_position(in_pos), .o_active(active), .o_hit(hit),
    .o_miss(miss), .o_spawn_dropped(dropped), .o_score(score), .o_combo(combo),
    .o_best_combo(best), .o_state(state)
  );

`ifdef LANE_JUDGE_EARLY_PENALTY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // lane model: phase 0 idle, 1 falling, 2 hittable, 3 cooling down
  int       m_phase, m_frames, m_score, m_combo, m_best;
  bit       m_pend, m_hit, m_miss, m_drop, m_active;
  bit [2:0] vs_h, bt_h;

  task automatic model_step();
    bit tick, prs;
    tick = vs_h[1] & ~vs_h[2];
    prs  = bt_h[1] & ~bt_h[2];
    if (rst) begin
      m_phase = 0; m_frames = 0; m_score = 0; m_combo = 0; m_best = 0;
      m_pend = 0; m_hit = 0; m_miss = 0; m_drop = 0; m_active = 0;
      vs_h = 3'b0; bt_h = 3'b0;
    end else begin
      vs_h = {vs_h[1:0], v_sync};
      bt_h = {bt_h[1:0], button};
      m_hit = 0; m_miss = 0; m_drop = 0;
      m_active = (m_phase == 1) || (m_phase == 2);
      if (spawn && m_phase != 0) begin
        if (m_pend) m_drop = 1; else m_pend = 1;
      end
      case (m_phase)
        0: if (spawn || m_pend) begin m_phase = 1; m_frames = 0; m_pend = 0; end
        1: begin
          if (in_pos) begin m_phase = 2; m_frames = 0; end
          else if (EARLY && prs) m_miss = 1;
          else if (tick) begin m_frames++; if (m_frames == 64) m_miss = 1; end
        end
        2: begin
          if (prs) m_hit = 1;
          else if (!in_pos) m_miss = 1;
          else if (tick) begin m_frames++; if (m_frames == 17) m_miss = 1; end
        end
        default: if (tick) begin
          m_frames++;
          if (m_frames == 2) begin m_phase = 0; m_frames = 0; end
        end
      endcase
      if (m_hit) begin
        m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
        m_combo = (m_combo < 255) ? m_combo + 1 : 255;
        if (m_combo > m_best) m_best = m_combo;
      end
      if (m_miss) m_combo = 0;
      if (m_hit || m_miss) begin m_phase = 3; m_frames = 0; end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (hit === 1'b1) hit_cnt++;
    if (miss === 1'b1) miss_cnt++;
    if (cmp_en) begin
      tests++;
      if ({active, hit, miss, dropped, score, combo, best, state} !==
          {m_active, m_hit, m_miss, m_drop, m_score[15:0], m_combo[7:0], m_best[7:0], m_phase[1:0]}) begin
        fails++;
        $display("FAIL cycle_compare t=%0t dut act/hit/miss/drop=%b%b%b%b sc=%0d cb=%0d best=%0d st=%0d model %b%b%b%b sc=%0d cb=%0d best=%0d st=%0d",
                 $time, active, hit, miss, dropped, score, combo, best, state,
                 m_active, m_hit, m_miss, m_drop, m_score, m_combo, m_best, m_phase);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic vpulse();
    v_sync = 1'b1; step(2);
    v_sync = 1'b0; step(2);
  endtask

  task automatic press_btn();
    button = 1'b1; step(2);
    button = 1'b0; step(3);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (state != 2'd0 && n < 40) begin vpulse(); n++; end
    chk("reach_idle", int'(state), 0);
  endtask

  task automatic goto_window();
    int n = 0;
    in_pos = 1'b1;
    while (state != 2'd2 && n < 200) begin
      if (state == 2'd3) vpulse();
      else if (state == 2'd0) begin spawn = 1'b1; step(1); spawn = 1'b0; end
      else step(1);
      n++;
    end
    chk("reach_window", int'(state), 2);
  endtask

  task automatic hit_seq();
    spawn = 1'b1; step(1); spawn = 1'b0;
    in_pos = 1'b1; step(2);
    press_btn();
    in_pos = 1'b0;
    wait_idle();
  endtask

  int h0, mi0, n;

  initial begin
    rst = 1'b1; v_sync = 1'b0; spawn = 1'b0; button = 1'b0; in_pos = 1'b0;
    step(1);
    cmp_en = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
    chk("reset_state", int'(state), 0);
    chk("reset_flags", int'({active, hit, miss, dropped, combo, best}), 0);
    chk("reset_score", int'(score), 0);

    // first hit with exact latency
    spawn = 1'b1; step(1); spawn = 1'b0;
    chk("spawn_state", int'(state), 1);
    chk("spawn_active_lag", int'(active), 0);
    step(1);
    chk("spawn_active", int'(active), 1);
    in_pos = 1'b1; step(1);
    chk("window_state", int'(state), 2);
    h0 = hit_cnt;
    button = 1'b1; step(1);
    chk("hit_lat1", int'(hit), 0);
    step(1); button = 1'b0;
    chk("hit_lat2", int'(hit), 0);
    step(1);
    chk("hit_lat3", int'(hit), 1);
    chk("hit_score", int'(score), 10);
    chk("hit_combo", int'(combo), 1);
    chk("hit_state", int'(state), 3);
    step(1);
    chk("cool_active", int'(active), 0);
    in_pos = 1'b0; step(2);
    chk("hit_once", hit_cnt - h0, 1);
    vpulse();
    chk("cool_one_tick", int'(state), 3);
    vpulse();
    chk("cool_done", int'(state), 0);

    // three hits then window expiry
    hit_seq(); hit_seq();
    chk("three_score", int'(score), 30);
    chk("three_combo", int'(combo), 3);
    spawn = 1'b1; step(1); spawn = 1'b0; in_pos = 1'b1; step(2);
    mi0 = miss_cnt;
    repeat (16) vpulse();
    chk("win16_nomiss", miss_cnt - mi0, 0);
    chk("win16_state", int'(state), 2);
    vpulse();
    chk("win17_miss", miss_cnt - mi0, 1);
    chk("win17_combo", int'(combo), 0);
    chk("win17_best", int'(best), 3);
    chk("win17_score", int'(score), 30);
    in_pos = 1'b0; wait_idle();

    // travel timeout
    spawn = 1'b1; step(1); spawn = 1'b0; step(1);
    mi0 = miss_cnt;
    repeat (63) vpulse();
    chk("trav63_nomiss", miss_cnt - mi0, 0);
    chk("trav63_state", int'(state), 1);
    vpulse();
    chk("trav64_miss", miss_cnt - mi0, 1);
    chk("trav64_state", int'(state), 3);
    wait_idle();

    // press while travelling
    spawn = 1'b1; step(1); spawn = 1'b0; step(2);
    mi0 = miss_cnt;
    press_btn();
`ifdef LANE_JUDGE_EARLY_PENALTY_EN
    chk("early_miss", miss_cnt - mi0, 1);
    chk("early_state", int'(state), 3);
    chk("early_active", int'(active), 0);
`else
    chk("early_ignored", miss_cnt - mi0, 0);
    chk("early_state", int'(state), 1);
    chk("early_active", int'(active), 1);
`endif
    in_pos = 1'b1; step(1); in_pos = 1'b0; step(2);
    wait_idle();

    // pending spawn and dropped request
    spawn = 1'b1; step(1);
    chk("pend_state", int'(state), 1);
    step(1);
    chk("pend_nodrop", int'(dropped), 0);
    step(1); spawn = 1'b0;
    chk("pend_drop", int'(dropped), 1);
    step(1);
    chk("pend_drop_pulse", int'(dropped), 0);
    in_pos = 1'b1; step(1);
    press_btn();
    in_pos = 1'b0;
    chk("pend_cool", int'(state), 3);
    vpulse(); vpulse();
    chk("pend_autospawn", int'(state), 1);
    in_pos = 1'b1; step(1); in_pos = 1'b0; step(2);
    wait_idle();

    // same-cycle press and final window tick
    spawn = 1'b1; step(1); spawn = 1'b0; in_pos = 1'b1; step(2);
    repeat (16) vpulse();
    h0 = hit_cnt; mi0 = miss_cnt;
    v_sync = 1'b1; button = 1'b1; step(2);
    v_sync = 1'b0; button = 1'b0; step(4);
    chk("tie_hit", hit_cnt - h0, 1);
    chk("tie_nomiss", miss_cnt - mi0, 0);
    in_pos = 1'b0; wait_idle();

    // reset in WINDOW
    spawn = 1'b1; step(1); spawn = 1'b0; in_pos = 1'b1; step(2);
    chk("prerst_state", int'(state), 2);
    rst = 1'b1; step(1);
    chk("rst_score", int'(score), 0);
    chk("rst_flags", int'({active, hit, miss, dropped, combo, best, state}), 0);
    rst = 1'b0; in_pos = 1'b0;
    h0 = hit_cnt; mi0 = miss_cnt;
    press_btn(); step(1);
    chk("rst_press_quiet", (hit_cnt - h0) + (miss_cnt - mi0), 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      spawn = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) in_pos = ~in_pos;
      if ($urandom_range(0, 2) == 0) v_sync = ~v_sync;
      if ($urandom_range(0, 3) == 0) button = ~button;
      step(1);
    end

    // score and combo saturation
    rst = 1'b1; spawn = 1'b0; v_sync = 1'b0; button = 1'b1; in_pos = 1'b1;
    step(2);
    rst = 1'b0; spawn = 1'b1;
    n = 0;
    while (n < 60000) begin
      step(1);
      if (m_score >= 65530) break;
      v_sync = ~v_sync; button = ~button;
      n++;
    end
    spawn = 1'b0; v_sync = 1'b0; button = 1'b0;
    chk("sat_preload", int'(score), 65530);
    chk("sat_combo", int'(combo), 255);
    goto_window();
    press_btn();
    chk("sat_score", int'(score), 65535);
    goto_window();
    press_btn();
    chk("sat_score_hold", int'(score), 65535);
    chk("sat_combo_hold", int'(combo), 255);
    chk("sat_best", int'(best), 255);
    in_pos = 1'b0; step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lane_judge.md
Name: lane_judge

Overview:
- Controls a single falling-coin lane and judges the player's press against it.
- Drives the coin sprite's `active` input to spawn and retire the coin, and watches the coin's `in_position` output for the hit window.
- Samples the player button, then issues hit/miss pulses and maintains score and combo.
- Sits between the input/game-control logic and one coin sprite instance, one lane_judge per lane.

Parameters:
- WINDOW_FRAMES, 17, max frames the hit window stays open after in_position rises (coin moves 10 px/frame over a 170 px zone).
- TRAVEL_TIMEOUT, 64, frames in TRAVEL without in_position before a forced miss.
- COOLDOWN_FRAMES, 2, frames active is held low before the next spawn; the coin resets its position on v_sync while inactive, so the minimum is 1.
- SCORE_PER_HIT, 10, score increment per hit.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_v_sync  in  1  frame sync (async to i_clk); its rising edge is one frame tick
- i_spawn_req  in  1  single-cycle request to launch a coin
- i_button  in  1  raw player button (async), 1 = pressed
- i_in_position  in  1  from coin: coin is in the hittable zone
- o_active  out  1  to coin active input
- o_hit  out  1  single-cycle hit pulse
- o_miss  out  1  single-cycle miss pulse
- o_spawn_dropped  out  1  single-cycle pulse when a spawn request is lost
- o_score  out  16  accumulated score
- o_combo  out  8  current consecutive hits
- o_best_combo  out  8  highest combo since reset
- o_state  out  2  FSM state: 0 IDLE, 1 TRAVEL, 2 WINDOW, 3 COOLDOWN

Behaviour:

Reset:
- Any cycle with i_rst=1: state IDLE, all outputs 0, synchronizers and counters 0, pending flag clear.
- Reset mid-operation drops o_active the same cycle it registers.

Input conditioning:
- i_v_sync and i_button each pass through a 2-flop synchronizer, then a rising-edge detect.
- `frame_tick` and `press` are one-cycle strobes, 3 i_clk cycles after the raw rising edge.
- i_in_position is used unsynchronized; it is frame-stable and derived from i_v_sync-domain state.

FSM (all outputs registered):
- IDLE: o_active=0. On i_spawn_req or pending set: go to TRAVEL, o_active=1 next cycle, clear pending, frame counter=0.
- TRAVEL:
  - frame counter increments on frame_tick.
  - When i_in_position=1: go to WINDOW, counter=0.
  - When counter reaches TRAVEL_TIMEOUT: miss, go to COOLDOWN.
  - press is ignored.
- WINDOW:
  - If press occurs: o_hit pulse; score += SCORE_PER_HIT, saturating at 16'hFFFF; combo += 1, saturating at 255; best_combo = max(best_combo, new combo). Go to COOLDOWN.
  - Else if i_in_position=0, or the counter reaches WINDOW_FRAMES on frame_tick: miss, go to COOLDOWN.
  - If press and window expiry happen in the same cycle, the hit wins.
- COOLDOWN:
  - Entered with the frame counter cleared.
  - o_active=0 on the cycle after entry.
  - After COOLDOWN_FRAMES frame_ticks, go to IDLE.

Miss action:
- o_miss pulse for one cycle, combo=0, score unchanged.

Spawn buffering:
- An i_spawn_req outside IDLE sets a one-deep pending flag.
- A request while pending is already set pulses o_spawn_dropped and changes nothing else.
- A request in IDLE in the same cycle pending is set is serviced once; pending clears.

Other rules:
- o_hit and o_miss are never high in the same cycle.
- All counters are 8 bits wide, and parameters must be ≤255.

Optional Feature:
- Macro: LANE_JUDGE_EARLY_PENALTY_EN.
- Defined: press in TRAVEL counts as an early miss — o_miss pulse, combo=0, go to COOLDOWN, o_active dropped.
- Undefined: press in TRAVEL is ignored, as above.

Test Plan:
- Reset then spawn pulse: o_state 0→1, o_active=1 one cycle later; raise i_in_position → state 2; button rise → o_hit exactly once 3 cycles later, o_score=10, o_combo=1, state 3, o_active=0; after 2 v_sync edges → state 0.
- Three hits then window expiry: hold i_in_position=1 without pressing for 17 v_sync edges → o_miss once; o_combo=0, o_best_combo=3, o_score=30.
- No in_position for 64 frames → o_miss, state COOLDOWN; with LANE_JUDGE_EARLY_PENALTY_EN, a press in TRAVEL → immediate o_miss; without the macro, no response to that press.
- Spawn in TRAVEL sets pending; a further spawn → o_spawn_dropped pulse; after cooldown the FSM auto-enters TRAVEL without a new request.
- Preload score to 65530 via hits: the next hit gives 65535 (saturated). Press and final window frame_tick in the same cycle → o_hit only.
- Assert i_rst in WINDOW → next cycle all outputs 0, state IDLE; a press right after reset causes no pulse.
